// File: rtl/usb_link_mon.sv
`default_nettype none
// ============================================================================
// usb_link_mon -- USB full-speed bus-state monitor: bus reset, suspend,
// host resume and remote-wakeup K drive, with sticky maskable events.
// Revision: 1.0
// ============================================================================
module usb_link_mon #(
  parameter int unsigned CLK_FREQ      = 48000000,
  parameter int unsigned RESET_US      = 2500,
  parameter int unsigned SUSPEND_US    = 3000,
  parameter string       IDLE_SRC      = "LINE",
  parameter int unsigned RESUME_DET_US = 50,
  parameter int unsigned RWK_IDLE_US   = 5000,
  parameter int unsigned RWK_DRIVE_US  = 2000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_dp,
  input  logic       rx_dn,
  input  logic       sof_stb,
  input  logic       rwk_ena,
  input  logic       rwk_req,
  input  logic [3:0] evt_clr,
  input  logic [3:0] irq_mask,
  output logic       usb_rst,
  output logic       suspend,
  output logic       tx_en,
  output logic       tx_dp,
  output logic       tx_dn,
  output logic [3:0] evt,
  output logic       irq
);

  localparam int unsigned DIV    = CLK_FREQ / 1000000;
  localparam int unsigned PW     = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned SE0_W  = $clog2(RESET_US + 1);
  localparam int unsigned IDLE_W = $clog2(SUSPEND_US + 1);
  localparam int unsigned K_W    = $clog2(RESUME_DET_US + 1);
  localparam int unsigned ST_MAX = (RWK_IDLE_US > RWK_DRIVE_US) ? RWK_IDLE_US : RWK_DRIVE_US;
  localparam int unsigned ST_W   = $clog2(ST_MAX + 1);

  typedef enum logic [2:0] {
    ST_RESET     = 3'd0,
    ST_ACTIVE    = 3'd1,
    ST_SUSPEND   = 3'd2,
    ST_RWK_DRIVE = 3'd3,
    ST_RESUME    = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [PW-1:0]       presc_q, presc_d;
  logic [SE0_W-1:0]    se0_cnt_q, se0_cnt_d;
  logic [IDLE_W-1:0]   idle_cnt_q, idle_cnt_d;
  logic [K_W-1:0]      k_cnt_q, k_cnt_d;
  logic [ST_W-1:0]     st_cnt_q, st_cnt_d;
  logic                rwk_pend_q, rwk_pend_d;
  logic                se0_prev_q;
  logic [3:0]          evt_q, evt_d;
  logic                irq_q;

  logic                us_tick;
  logic                in_drive;
  logic                k_smp;
  logic                se0_smp;
  logic                idle_line_clr;
  logic                idle_clr;
  logic                se0_hit;
  logic                idle_hit;
  logic                k_hit;
  logic                drv_hit;
  logic                rwk_due;
  logic                idle_rst;
  logic [3:0]          evt_set;

  // Line samples are masked while we drive K ourselves so our own echo is ignored.
  assign in_drive = (state_q == ST_RWK_DRIVE);
  assign k_smp    = ~rx_dp &  rx_dn & ~in_drive;
  assign se0_smp  = ~rx_dp & ~rx_dn & ~in_drive;

  generate
    if (IDLE_SRC == "LINE") begin : g_idle_line
      assign idle_line_clr = k_smp | se0_smp;
    end else begin : g_idle_sof
      assign idle_line_clr = 1'b0;
    end
  endgenerate

  assign us_tick  = (presc_q == PW'(DIV - 1));
  assign idle_clr = sof_stb | idle_line_clr;

  assign se0_hit  = se0_smp & us_tick & (se0_cnt_q == SE0_W'(RESET_US - 1));
  assign idle_hit = ~idle_clr & us_tick & (idle_cnt_q == IDLE_W'(SUSPEND_US - 1));
  assign k_hit    = k_smp & us_tick & (k_cnt_q == K_W'(RESUME_DET_US - 1));
  assign drv_hit  = us_tick & (st_cnt_q == ST_W'(RWK_DRIVE_US - 1));
  assign rwk_due  = rwk_pend_q & (st_cnt_q >= ST_W'(RWK_IDLE_US));

  always_comb begin
    state_d  = state_q;
    evt_set  = 4'b0000;
    idle_rst = 1'b0;
    if (se0_hit) begin
      state_d    = ST_RESET;
      evt_set[0] = 1'b1;
    end else begin
      case (state_q)
        ST_RESET: begin
          if (!se0_smp) begin
            state_d  = ST_ACTIVE;
            idle_rst = 1'b1;
          end
        end
        ST_ACTIVE: begin
          if (idle_hit) begin
            state_d    = ST_SUSPEND;
            evt_set[1] = 1'b1;
          end
        end
        ST_SUSPEND: begin
          // Host resume takes precedence over a simultaneously due wakeup.
          if (k_hit) begin
            state_d    = ST_RESUME;
            evt_set[2] = 1'b1;
          end else if (rwk_due) begin
            state_d = ST_RWK_DRIVE;
          end
        end
        ST_RWK_DRIVE: begin
          if (drv_hit) begin
            state_d    = ST_RESUME;
            evt_set[3] = 1'b1;
          end
        end
        ST_RESUME: begin
          if (se0_prev_q && !se0_smp) begin
            state_d  = ST_ACTIVE;
            idle_rst = 1'b1;
          end
        end
        default: state_d = ST_RESET;
      endcase
    end
  end

  always_comb begin
    presc_d = us_tick ? '0 : presc_q + PW'(1);

    se0_cnt_d = se0_cnt_q;
    if (!se0_smp)
      se0_cnt_d = '0;
    else if (us_tick && se0_cnt_q != SE0_W'(RESET_US))
      se0_cnt_d = se0_cnt_q + SE0_W'(1);

    idle_cnt_d = idle_cnt_q;
    if (idle_clr || idle_rst)
      idle_cnt_d = '0;
    else if (us_tick && idle_cnt_q != IDLE_W'(SUSPEND_US))
      idle_cnt_d = idle_cnt_q + IDLE_W'(1);

    k_cnt_d = k_cnt_q;
    if (!k_smp)
      k_cnt_d = '0;
    else if (us_tick && k_cnt_q != K_W'(RESUME_DET_US))
      k_cnt_d = k_cnt_q + K_W'(1);

    st_cnt_d = st_cnt_q;
    if (state_d != state_q)
      st_cnt_d = '0;
    else if (us_tick && st_cnt_q != ST_W'(ST_MAX))
      st_cnt_d = st_cnt_q + ST_W'(1);

    rwk_pend_d = rwk_pend_q;
    if (state_q != ST_SUSPEND || state_d != ST_SUSPEND || !rwk_ena)
      rwk_pend_d = 1'b0;
    else if (rwk_req)
      rwk_pend_d = 1'b1;

    // Setting an event beats clearing it in the same cycle.
    evt_d = (evt_q & ~evt_clr) | evt_set;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_RESET;
      presc_q    <= '0;
      se0_cnt_q  <= '0;
      idle_cnt_q <= '0;
      k_cnt_q    <= '0;
      st_cnt_q   <= '0;
      rwk_pend_q <= 1'b0;
      se0_prev_q <= 1'b0;
      evt_q      <= 4'b0000;
      irq_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      presc_q    <= presc_d;
      se0_cnt_q  <= se0_cnt_d;
      idle_cnt_q <= idle_cnt_d;
      k_cnt_q    <= k_cnt_d;
      st_cnt_q   <= st_cnt_d;
      rwk_pend_q <= rwk_pend_d;
      se0_prev_q <= se0_smp;
      evt_q      <= evt_d;
      irq_q      <= |(evt_q & irq_mask);
    end
  end

  assign usb_rst = (state_q == ST_RESET);
  assign suspend = (state_q == ST_SUSPEND);
  assign tx_en   = in_drive;
  assign tx_dp   = 1'b0;
  assign tx_dn   = in_drive;
  assign evt     = evt_q;
  assign irq     = irq_q;

endmodule
`default_nettype wire

// File: tb/tb_usb_link_mon.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_usb_link_mon -- directed bench for usb_link_mon at 4 MHz, short timings.
// Revision: 1.0
// ============================================================================
module tb_usb_link_mon;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_dp = 1'b1;
  logic       rx_dn = 1'b0;
  logic       sof_stb = 1'b0;
  logic       rwk_ena = 1'b0;
  logic       rwk_req = 1'b0;
  logic [3:0] evt_clr = 4'b0000;
  logic [3:0] irq_mask = 4'b0000;
  logic       usb_rst, suspend, tx_en, tx_dp, tx_dn, irq;
  logic [3:0] evt;

  int checks = 0;
  int errors = 0;

  usb_link_mon #(
    .CLK_FREQ      (4000000),
    .RESET_US      (10),
    .SUSPEND_US    (30),
    .IDLE_SRC      ("LINE"),
    .RESUME_DET_US (2),
    .RWK_IDLE_US   (5),
    .RWK_DRIVE_US  (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rx_dp    (rx_dp),
    .rx_dn    (rx_dn),
    .sof_stb  (sof_stb),
    .rwk_ena  (rwk_ena),
    .rwk_req  (rwk_req),
    .evt_clr  (evt_clr),
    .irq_mask (irq_mask),
    .usb_rst  (usb_rst),
    .suspend  (suspend),
    .tx_en    (tx_en),
    .tx_dp    (tx_dp),
    .tx_dn    (tx_dn),
    .evt      (evt),
    .irq      (irq)
  );

  always #5 clk = ~clk;

  initial begin
    #200us;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic       rst;
    logic       dp;
    logic       dn;
    logic       exp_rst;
    logic       exp_susp;
    logic       exp_tx;
    logic [3:0] exp_evt;
    logic       exp_irq;
  } vec_t;

  vec_t tv [11];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_line(input logic dp, input logic dn);
    rx_dp = dp;
    rx_dn = dn;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input int n, input int lo, input int hi);
    checks++;
    if (n < lo || n > hi) begin
      errors++;
      $display("FAIL %s: got %0d clocks expected %0d..%0d", name, n, lo, hi);
    end
  endtask

  function automatic logic sig(input int sel);
    case (sel)
      0:       return usb_rst;
      1:       return suspend;
      default: return tx_en;
    endcase
  endfunction

  // Returns the number of clocks until the selected output reaches val, or max+1.
  task automatic wait_for(input int sel, input logic val, input int max, output int n);
    n = max + 1;
    for (int i = 1; i <= max; i++) begin
      step();
      if (sig(sel) === val) begin
        n = i;
        break;
      end
    end
  endtask

  initial begin
    int   n;
    int   m;
    logic seen;

    //        rst   dp    dn    usb_rst susp  tx    evt    irq
    tv[0]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0};
    tv[1]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0};
    tv[2]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0};
    tv[3]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0};
    tv[4]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0};
    tv[5]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0};
    tv[6]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0};
    tv[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0};
    tv[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0};
    tv[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0};
    tv[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0};

    for (int i = 0; i < 11; i++) begin
      rst = tv[i].rst;
      set_line(tv[i].dp, tv[i].dn);
      step();
      check($sformatf("vec%0d {usb_rst,suspend,tx_en,evt,irq}", i),
            {24'd0, usb_rst, suspend, tx_en, evt, irq},
            {24'd0, tv[i].exp_rst, tv[i].exp_susp, tv[i].exp_tx, tv[i].exp_evt, tv[i].exp_irq});
    end

    // Bus reset after 10 us of SE0.
    set_line(1'b0, 1'b0);
    wait_for(0, 1'b1, 60, n);
    check_range("se0 reset latency", n, 36, 40);
    check("evt after bus reset", evt, 4'b0001);
    set_line(1'b1, 1'b0);
    step();
    check("usb_rst release", usb_rst, 1'b0);
    evt_clr = 4'b0001;
    step();
    evt_clr = 4'b0000;
    check("evt cleared", evt, 4'b0000);

    // 8 us of SE0 must not reset.
    set_line(1'b0, 1'b0);
    seen = 1'b0;
    repeat (32) begin
      step();
      seen |= usb_rst;
    end
    check("short se0 no reset", seen, 1'b0);

    // Idle J leads to suspend.
    irq_mask = 4'b0010;
    set_line(1'b1, 1'b0);
    wait_for(1, 1'b1, 140, n);
    check_range("suspend latency", n, 116, 121);
    check("evt after suspend", evt, 4'b0010);
    check("irq lags evt", irq, 1'b0);
    step();
    check("irq after suspend", irq, 1'b1);
    evt_clr = 4'b0010;
    step();
    evt_clr = 4'b0000;
    check("evt suspend cleared", evt, 4'b0000);
    step();
    check("irq cleared", irq, 1'b0);

    // 1 us of K is too short for host resume.
    set_line(1'b0, 1'b1);
    repeat (4) step();
    set_line(1'b1, 1'b0);
    repeat (8) step();
    check("short K stays suspended", suspend, 1'b1);

    // Host resume: K 3 us, SE0 2 us, then J.
    set_line(1'b0, 1'b1);
    wait_for(1, 1'b0, 12, n);
    check_range("resume detect latency", n, 5, 8);
    check("evt resume bit", evt & 4'b0100, 4'b0100);
    check("no usb_rst on resume", usb_rst, 1'b0);
    if (n < 12) repeat (12 - n) step();
    set_line(1'b0, 1'b0);
    repeat (8) step();
    set_line(1'b1, 1'b0);
    wait_for(1, 1'b1, 140, n);
    check_range("active after resume then suspend", n, 116, 121);

    // Remote wakeup requested 1 us after entering suspend.
    evt_clr = 4'b1111;
    step();
    evt_clr = 4'b0000;
    repeat (3) step();
    rwk_ena = 1'b1;
    rwk_req = 1'b1;
    step();
    rwk_req = 1'b0;
    check("tx_en idle before rwk", tx_en, 1'b0);
    wait_for(2, 1'b1, 30, m);
    check_range("rwk start after suspend entry", 5 + m, 17, 22);
    check("rwk tx_dp", tx_dp, 1'b0);
    check("rwk tx_dn", tx_dn, 1'b1);
    check("suspend low during drive", suspend, 1'b0);
    wait_for(2, 1'b0, 20, m);
    check_range("rwk drive length", m, 12, 16);
    check("evt after rwk", evt, 4'b1000);
    check("no usb_rst after rwk", usb_rst, 1'b0);
    check("resume state not suspended", suspend, 1'b0);
    rwk_ena = 1'b0;

    // Host completes resume; return to ACTIVE and then suspend again.
    set_line(1'b0, 1'b0);
    repeat (4) step();
    set_line(1'b1, 1'b0);
    wait_for(1, 1'b1, 140, n);
    check_range("active after rwk then suspend", n, 116, 121);

    // Request without rwk_ena is ignored.
    repeat (4) step();
    rwk_req = 1'b1;
    step();
    rwk_req = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      step();
      seen |= tx_en;
    end
    check("no drive when rwk disabled", seen, 1'b0);
    check("still suspended", suspend, 1'b1);

    // Reset asserted mid-drive.
    rwk_ena = 1'b1;
    rwk_req = 1'b1;
    step();
    rwk_req = 1'b0;
    wait_for(2, 1'b1, 10, m);
    check_range("late rwk start", m, 1, 3);
    repeat (2) step();
    rst = 1'b1;
    step();
    check("tx_en drops on rst", tx_en, 1'b0);
    check("usb_rst on rst", usb_rst, 1'b1);
    check("evt cleared by rst", evt, 4'b0000);
    check("irq cleared by rst", irq, 1'b0);
    rst = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
